// File: rtl/memory_read_arbiter_pkg.sv
// Shared types, default sizes and the round-robin pick function for memory_read_arbiter.
package memory_read_arbiter_pkg;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_ADDR_WIDTH    = 10;
  localparam int DEF_MEMORY_WIDTH  = 40;
  localparam int DEF_READ_LATENCY  = 2;
  localparam int MAX_REQ           = 16;
  localparam int PTR_W             = 4;

  typedef struct packed {
    logic                      valid;
    logic [DEF_NUM_REQ-1:0]    owner;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } rd_tag_t;

  // One-hot grant for the first set bit of req_vec at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    logic [PTR_W-1:0]   sel;
    int                 idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        sel = PTR_W'(idx);
        if (!found && req_vec[sel]) begin
          grant[sel] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/memory_read_tag_pipe.sv
// Fixed-depth shift register carrying in-flight read tags; cleared by synchronous active-low reset.
module memory_read_tag_pipe
  import memory_read_arbiter_pkg::*;
#(
  parameter int  DEPTH = DEF_READ_LATENCY,
  parameter type tag_t = rd_tag_t
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/memory_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory read port; returns tagged data and broadcasts it.
// Optional MEMORY_READ_ARBITER_COALESCE_EN: requesters asking for the granted address share the access.
module memory_read_arbiter
  import memory_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = DEF_NUM_REQ,
  parameter int MEMORY_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEMORY_WIDTH      = DEF_MEMORY_WIDTH,
  parameter int READ_LATENCY      = DEF_READ_LATENCY
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*MEMORY_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [MEMORY_WIDTH-1:0]              rsp_data,
  output logic                                 mem_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]         mem_addr,
  input  logic                                 mem_ready,
  input  logic [MEMORY_WIDTH-1:0]              mem_data,
  output logic                                 broadcast_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]         broadcast_addr
);

  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic               valid;
    logic [NUM_REQ-1:0] owner;
    logic [AW-1:0]      addr;
  } tag_t;

  logic [PW-1:0]      rr_ptr;
  logic [MAX_REQ-1:0] pick_full;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      gidx;
  logic [AW-1:0]      gaddr;
  logic               accept;
  logic               unused_pick;
  tag_t               tag_in;
  tag_t               tag_out;

  assign pick_full   = rr_pick(MAX_REQ'(req_valid), PTR_W'(rr_ptr), NUM_REQ);
  assign grant       = pick_full[NUM_REQ-1:0];
  assign unused_pick = ^pick_full;

  always_comb begin
    gidx  = '0;
    gaddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx  = PW'(i);
        gaddr = req_addr[i*AW +: AW];
      end
    end
  end

  // Outputs are forced quiet while reset is held so nothing is issued into a clearing pipeline.
  assign mem_valid = rst_n & (|req_valid);
  assign mem_addr  = rst_n ? gaddr : '0;
  assign accept    = mem_valid & mem_ready;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = grant;
`ifdef MEMORY_READ_ARBITER_COALESCE_EN
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (req_addr[i*AW +: AW] == gaddr)) req_ready[i] = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
    end
  end

  assign tag_in.valid = accept;
  assign tag_in.owner = req_ready;
  assign tag_in.addr  = gaddr;

  memory_read_tag_pipe #(
    .DEPTH (READ_LATENCY),
    .tag_t (tag_t)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid       <= '0;
      rsp_data        <= '0;
      broadcast_valid <= 1'b0;
      broadcast_addr  <= '0;
    end else begin
      rsp_valid       <= tag_out.valid ? tag_out.owner : '0;
      broadcast_valid <= tag_out.valid;
      if (tag_out.valid) begin
        rsp_data       <= mem_data;
        broadcast_addr <= tag_out.addr;
      end
    end
  end

endmodule

// File: doc/memory_read_arbiter.md
Name: memory_read_arbiter

Overview:
- Shares one single-port memory read channel between NUM_REQ requesters using round-robin arbitration.
- Tracks in-flight reads with a fixed-latency tag pipeline and steers returned data to the requester that owns it.
- Broadcasts every returned word with its address so non-owning requesters can snoop it.
- Sits between the requester engines and the memory read port (ready/addr/valid/data plus broadcast_addr/broadcast_valid).

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MEMORY_ADDR_WIDTH, 10, read address width.
- MEMORY_WIDTH, 40, read data width.
- READ_LATENCY, 2, cycles from an accepted memory request to mem_data valid (1..8).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*MEMORY_ADDR_WIDTH  packed addresses; requester i at slice i.
- req_ready  out  NUM_REQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot: rsp_data belongs to requester i.
- rsp_data  out  MEMORY_WIDTH  returned read data, shared by all requesters.
- mem_valid  out  1  memory request valid.
- mem_addr  out  MEMORY_ADDR_WIDTH  memory request address.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_data  in  MEMORY_WIDTH  memory read data, valid READ_LATENCY cycles after acceptance.
- broadcast_valid  out  1  returned word valid for snooping.
- broadcast_addr  out  MEMORY_ADDR_WIDTH  address of the returned word.

Behaviour:
- Reset (rst_n=0 at a clk edge): req_ready=0, rsp_valid=0, mem_valid=0, broadcast_valid=0, rsp_data=0, mem_addr=0, broadcast_addr=0, rr pointer=0, tag pipeline cleared.
- Reset mid-operation: all in-flight reads are dropped. No rsp_valid is issued for them, even if mem_data later arrives.
- Arbitration (combinational, same cycle):
  - Grant the first requester with req_valid=1, searching from rr_ptr upward with wrap-around modulo NUM_REQ.
  - mem_valid = |req_valid; mem_addr = granted address.
  - req_ready[g] = mem_ready; all other req_ready bits are 0.
- Pointer update: on an accepted transfer (mem_valid & mem_ready), rr_ptr <= g+1, wrapping NUM_REQ-1 -> 0. The pointer holds otherwise.
- No requester waits more than NUM_REQ-1 accepted transfers.
- Stall: if mem_ready=0, there is no grant and no pointer change. Requesters must hold req_valid and req_addr until accepted.
- Tag pipeline: on acceptance, push {valid=1, owner one-hot, addr} into a READ_LATENCY-deep shift register; otherwise push valid=0. The pipeline advances every cycle.
- Response:
  - At pipeline output: rsp_valid = owner one-hot, rsp_data = mem_data, broadcast_valid = 1, broadcast_addr = addr.
  - Registered one cycle, so total request-to-response latency is READ_LATENCY+1.
- Throughput: one request accepted per cycle, back-to-back, with no bubbles.
- A requester may have up to READ_LATENCY+1 reads in flight. Responses return in issue order.
- All-idle: mem_valid=0, and the pipeline drains normally.

Optional Feature:
- Macro: MEMORY_READ_ARBITER_COALESCE_EN.
- Defined:
  - On acceptance, every requester with req_valid=1 and req_addr equal to the granted address also receives req_ready=1 that cycle.
  - Its owner bit is OR-ed into the tag, so rsp_valid is multi-hot for that word.
  - rr_ptr advances past the primary grant only.
- Undefined: req_ready and rsp_valid are strictly one-hot (zero-or-one), and duplicate addresses are served as separate reads.

Decomposition:
- Package memory_read_arbiter_pkg:
  - rd_tag_t struct {valid, owner[NUM_REQ], addr};
  - function rr_pick(req_vec, ptr) returning the one-hot grant.
  - Default width constants.
- Sub-module memory_read_tag_pipe: parameterised READ_LATENCY-deep shift register of rd_tag_t with synchronous active-low clear.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> all outputs 0; after release with no req_valid, mem_valid stays 0 and broadcast_valid stays 0.
- Single read: NUM_REQ=4, READ_LATENCY=2, req 2 addr 0x05, mem_ready=1, mem_data=0xAB_CDEF_0123 at +2 -> at +3: rsp_valid=4'b0100, rsp_data=0xAB_CDEF_0123, broadcast_valid=1, broadcast_addr=0x05.
- Fairness: all 4 requesters continuously valid for 8 accepted transfers -> grant order 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: mem_ready=0 for 3 cycles while req 1 is valid -> req_ready=0 and rr_ptr unchanged; with mem_ready=1 on cycle 4 -> granted; response 3 cycles later.
- Reset mid-flight: two reads accepted, rst_n=0 for 1 cycle before return -> no rsp_valid and no broadcast_valid for either.
- Coalesce (macro defined): req 0 and req 3 both at addr 0x1F in the same cycle -> one mem access, req_ready=4'b1001, rsp_valid=4'b1001. Without the macro -> two accesses on consecutive cycles.
